instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch stage for the single-issue RV32I core. It owns the program counter and issues word requests to instruction memory over a valid/ready interface.
- It buffers returned words in a small in-order prefetch FIFO and presents {instr, pc} to decode, where the immediate generator and control unit consume it.
- Redirects from branch/jump resolution flush all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch FIFO entries (power of two, >=2); also the cap on outstanding plus buffered fetches.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_resp_valid  input  1  response word valid; responses return in order, at least 1 cycle after acceptance.
- imem_resp_data  input  32  response instruction word.
- redirect_valid  input  1  taken branch/JAL/JALR from execute.
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  FIFO head valid.
- instr  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head.
- instr_ready  input  1  decode consumes the head (low = stall).

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=FETCH, FIFO empty, outstanding=0.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Credit rule: imem_req_valid=1 only in FETCH when outstanding + fifo_count < FIFO_DEPTH. imem_req_addr=pc.
- Request handshake:
  - On imem_req_valid&&imem_req_ready, pc<=pc+4 (wraps modulo 2^32) and outstanding increments.
  - Once asserted, imem_req_valid and addr are held stable until ready.
- Response handling:
  - In FETCH, imem_resp_valid pushes {imem_resp_data, pc_of_request} into the FIFO and decrements outstanding.
  - pc_of_request comes from a per-outstanding PC queue, or equivalently fifo tail PC + 4.
  - A push cannot overflow, by the credit rule.
- Output: instr/instr_pc/instr_valid are the registered FIFO head. A pop occurs on instr_valid&&instr_ready. Push and pop may happen in the same cycle, including when the FIFO is full with a response arriving.
- Redirect (highest priority, any state):
  - Same-cycle effects: FIFO cleared; pc<=redirect_pc with bits [1:0] forced to 00; any pending unaccepted request is withdrawn.
  - instr_valid=0 the next cycle.
  - If outstanding (after this cycle's accept/response) is nonzero, go to DRAIN, else stay in FETCH.
- DRAIN:
  - No requests issued.
  - Each imem_resp_valid is discarded and decrements outstanding.
  - When outstanding reaches 0, go to FETCH.
  - A redirect during DRAIN updates pc and stays in DRAIN.
- Redirect coinciding with a decode pop: the redirect wins and the popped entry is irrelevant.
- Redirect coinciding with a request accept: that request counts as outstanding and is drained.
- Latency:
  - Redirect to first request: 1 cycle, when nothing is outstanding.
  - Response to instr_valid: 1 cycle.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release for pre-reset requests are not the block's responsibility, because memory is reset together with the core.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0), registered.
  - Pulses for 1 cycle when redirect_valid arrives with redirect_pc[1:0]!=0.
  - The target still gets its bits [1:0] forced to 00.
- Undefined: the port is absent and the low bits are silently zeroed.

Decomposition:
- Shared package core_pkg:
  - XLEN=32.
  - ILEN=32.
  - Enum fetch_state_t {FETCH, DRAIN}.
  - Typedef fetch_entry_t {instr, pc}.
  - Default RESET_PC.
  - NOP encoding 32'h0000_0013.
- Sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with push/pop/flush/count and simultaneous push+pop when full.

Test Plan:
- Reset release, imem_req_ready=1, fixed 1-cycle response latency, instr_ready=1:
  - Addresses go 0x0, 0x4, 0x8.
  - instr_pc follows the same sequence with the matching data.
  - Throughput is 1 instruction/cycle after fill.
- instr_ready=0 for 5 cycles:
  - The FIFO fills to 2 and imem_req_valid drops.
  - No word is lost or duplicated on resume.
- Redirect to 0x100 with 2 requests outstanding:
  - Both late responses are discarded.
  - The next imem_req_addr is 0x100 after DRAIN.
  - The first instr_pc out is 0x100.
- imem_req_ready held 0 for 3 cycles: imem_req_valid and imem_req_addr stay stable until accepted.
- rst asserted mid-stream with the FIFO full: outputs go to 0 asynchronously, and the first request after release is RESET_PC.
- With IFETCH_MISALIGN_CHK_EN defined, redirect_pc=0x102: fetch_misalign pulses once and the fetch address is 0x100.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP          = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {FETCH, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO of fetch entries with flush; push+pop allowed when full.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A pop frees the slot the same cycle, so a full FIFO may still take a push.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem requests,
// buffers returned words and drains in-flight fetches after a redirect.
// Optional: IFETCH_MISALIGN_CHK_EN adds a fetch_misalign pulse output.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_MISALIGN_CHK_EN
  ,output logic       fetch_misalign
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_t  state, state_n;
  logic [31:0]   pc, resp_pc;
  logic [CW-1:0] outst, outst_n, fifo_cnt;
  logic [CW:0]   used;
  logic          pop, acc, dec, push;
  fetch_entry_t  head;

  assign pop  = instr_valid && instr_ready;
  // Credits count in-flight plus buffered words; a same-cycle pop frees one.
  assign used = {1'b0, outst} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};

  assign imem_req_valid = !rst && (state == FETCH) && (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign acc            = imem_req_valid && imem_req_ready;
  assign dec            = imem_resp_valid && (outst != '0);
  assign push           = (state == FETCH) && dec && !redirect_valid;
  assign outst_n        = outst + CW'(acc) - CW'(dec);

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{instr: imem_resp_data, pc: resp_pc}),
    .pop       (pop && !redirect_valid),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign instr_valid = (fifo_cnt != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  // Redirect drains whatever is still in flight; drain ends when nothing is left.
  always_comb begin
    state_n = state;
    if (redirect_valid)
      state_n = (outst_n != '0) ? DRAIN : FETCH;
    else if (state == DRAIN && outst_n == '0)
      state_n = FETCH;
  end

  // PC, PC of the next expected response, and in-flight request count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
      outst   <= '0;
    end else begin
      outst <= outst_n;
      if (redirect_valid) begin
        pc      <= align_pc(redirect_pc);
        resp_pc <= align_pc(redirect_pc);
      end else begin
        if (acc)  pc      <= pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
      end
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`endif
endmodule
